// File: rtl/lift_pkg.sv
// Shared lift definitions: hall-button bit layout, floor/direction mapping,
// motion Action encodings and scheduler states.
package lift_pkg;

  localparam int B1U = 0;
  localparam int B2U = 1;
  localparam int B3U = 2;
  localparam int B2D = 3;
  localparam int B3D = 4;
  localparam int B4D = 5;

  typedef enum logic [1:0] {
    ACT_UP    = 2'd0,
    ACT_DOWN  = 2'd1,
    ACT_STAY  = 2'd2,
    ACT_RESET = 2'd3
  } action_t;

  typedef enum logic [2:0] {
    S_INIT = 3'd0,
    S_IDLE = 3'd1,
    S_REQ  = 3'd2,
    S_MOVE = 3'd3,
    S_DOOR = 3'd4
  } state_t;

  // Floor that a hall button belongs to.
  function automatic logic [1:0] btn_floor(input int i);
    case (i)
      B1U:     return 2'd0;
      B2U:     return 2'd1;
      B3U:     return 2'd2;
      B2D:     return 2'd1;
      B3D:     return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

  // One-hot button for (floor, dir); zero where no such button exists.
  function automatic logic [5:0] btn_mask(input logic [1:0] f, input logic d);
    logic [5:0] m;
    m = '0;
    case ({d, f})
      3'b000:  m[B1U] = 1'b1;
      3'b001:  m[B2U] = 1'b1;
      3'b010:  m[B3U] = 1'b1;
      3'b101:  m[B2D] = 1'b1;
      3'b110:  m[B3D] = 1'b1;
      3'b111:  m[B4D] = 1'b1;
      default: m = '0;
    endcase
    return m;
  endfunction

  function automatic logic [5:0] floor_mask(input logic [1:0] f);
    return btn_mask(f, 1'b0) | btn_mask(f, 1'b1);
  endfunction

endpackage

// File: rtl/lift_target_select.sv
// Combinational SCAN decision for one floor: which sides hold calls, whether
// the car should stop here, which bits that stop serves and the travel direction after it.
module lift_target_select
  import lift_pkg::*;
(
  input  logic [5:0] pending,
  input  logic [1:0] floor,
  input  logic       dir,
  output logic       above,
  output logic       below,
  output logic       stop_here,
  output logic       next_dir,
  output logic [5:0] clr_mask
);

  logic       beyond, opposite, rev;
  logic [5:0] same, opp;

  always_comb begin
    above = 1'b0;
    below = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (pending[i] && (btn_floor(i) > floor)) above = 1'b1;
      if (pending[i] && (btn_floor(i) < floor)) below = 1'b1;
    end
  end

  assign beyond   = dir ? below : above;
  assign opposite = dir ? above : below;
  assign same     = pending & btn_mask(floor, dir);
  assign opp      = pending & btn_mask(floor, ~dir);
  // Nothing further ahead: serve the opposite call here and turn round.
  assign rev       = !beyond && (|opp);
  assign stop_here = (|same) || rev;
  assign clr_mask  = same | (rev ? opp : 6'd0);
  assign next_dir  = rev ? ~dir : (beyond ? dir : (opposite ? ~dir : dir));

endmodule

// File: rtl/lift_request_scheduler.sv
// Directional (SCAN) scheduler for the 4-floor lift: sticky hall calls, one-floor
// step handshake, door dwell. Optional homing to floor 1 under LIFT_HOME_RETURN_EN.
module lift_request_scheduler
  import lift_pkg::*;
#(
  parameter int DWELL_CYCLES = 8,
  parameter int HOME_TIMEOUT = 64
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [5:0] HallReq,
  input  logic       StepReady,
  input  logic       Arrive,
  output logic       StepValid,
  output logic       StepDir,
  output logic [1:0] Action,
  output logic [1:0] Floor,
  output logic       DoorOpen,
  output logic [5:0] Pending
);

  localparam int CW = $clog2(DWELL_CYCLES + 1);
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);

  state_t        state, state_nxt;
  logic [1:0]    floor_q, floor_nxt, floor_eval;
  logic          dir, dir_nxt;
  logic [5:0]    pend, clr, here, door_clr;
  logic [CW-1:0] dwell, dwell_nxt;
  logic          above, below, stop_here, next_dir, at_term, idle_down;
  logic [5:0]    clr_mask;

`ifdef LIFT_HOME_RETURN_EN
  localparam int HW = $clog2(HOME_TIMEOUT + 1);
  localparam logic [HW-1:0] HOME_LAST = HW'(HOME_TIMEOUT - 1);
  logic [HW-1:0] home_cnt, home_cnt_nxt;
  logic          homing, homing_nxt;
`else
  if (HOME_TIMEOUT < 1) begin : g_home_timeout_unused
  end
`endif

  // While moving, evaluate the floor the car is about to reach.
  assign floor_eval = (state == S_MOVE) ? (dir ? floor_q - 2'd1 : floor_q + 2'd1) : floor_q;

  lift_target_select u_sel (
    .pending  (pend),
    .floor    (floor_eval),
    .dir      (dir),
    .above    (above),
    .below    (below),
    .stop_here(stop_here),
    .next_dir (next_dir),
    .clr_mask (clr_mask)
  );

  assign here     = pend & floor_mask(floor_q);
  assign at_term  = (floor_q == 2'd0) || (floor_q == 2'd3);
  assign door_clr = at_term ? here : (pend & btn_mask(floor_q, dir));
  // Nearer side from idle; ties go up. Only floor 1 can see a strictly nearer call below.
  assign idle_down = !above || ((floor_q == 2'd1) && below && !(|(pend & floor_mask(2'd2))));

  always_comb begin
    state_nxt = state;
    floor_nxt = floor_q;
    dir_nxt   = dir;
    clr       = '0;
    dwell_nxt = dwell;
    StepValid = 1'b0;
    DoorOpen  = 1'b0;
    Action    = ACT_STAY;
`ifdef LIFT_HOME_RETURN_EN
    home_cnt_nxt = '0;
    homing_nxt   = homing && !(|pend) && !(|HallReq);
`endif
    case (state)
      S_INIT: begin
        Action    = ACT_RESET;
        state_nxt = S_IDLE;
      end
      S_IDLE: begin
        if (|here) begin
          clr       = here;
          dwell_nxt = '0;
          state_nxt = S_DOOR;
        end else if (above || below) begin
          dir_nxt   = idle_down;
          state_nxt = S_REQ;
        end
`ifdef LIFT_HOME_RETURN_EN
        else if ((floor_q != 2'd0) && !(|HallReq)) begin
          if (home_cnt == HOME_LAST) begin
            dir_nxt    = 1'b1;
            homing_nxt = 1'b1;
            state_nxt  = S_REQ;
          end else begin
            home_cnt_nxt = home_cnt + HW'(1);
          end
        end
`endif
      end
      S_REQ: begin
        StepValid = 1'b1;
        Action    = dir ? ACT_DOWN : ACT_UP;
        if (StepReady) state_nxt = S_MOVE;
      end
      S_MOVE: begin
        Action = dir ? ACT_DOWN : ACT_UP;
        if (Arrive) begin
          floor_nxt = floor_eval;
          if (stop_here) begin
            clr       = clr_mask;
            dir_nxt   = next_dir;
            dwell_nxt = '0;
            state_nxt = S_DOOR;
          end else if (above || below) begin
            dir_nxt   = next_dir;
            state_nxt = S_REQ;
          end
`ifdef LIFT_HOME_RETURN_EN
          else if (homing && (floor_eval != 2'd0)) begin
            state_nxt = S_REQ;
          end
`endif
          else begin
            state_nxt = S_IDLE;
`ifdef LIFT_HOME_RETURN_EN
            homing_nxt = 1'b0;
`endif
          end
        end
      end
      S_DOOR: begin
        DoorOpen = 1'b1;
        if (|door_clr) begin
          clr       = door_clr;
          dwell_nxt = '0;
        end else if (dwell == DWELL_LAST) begin
          if (dir ? below : above) begin
            state_nxt = S_REQ;
          end else if (dir ? above : below) begin
            dir_nxt   = ~dir;
            state_nxt = S_REQ;
          end else begin
            state_nxt = S_IDLE;
          end
        end else begin
          dwell_nxt = dwell + CW'(1);
        end
      end
      default: begin
        Action    = ACT_RESET;
        state_nxt = S_INIT;
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state   <= S_INIT;
      floor_q <= 2'd0;
      dir     <= 1'b0;
      pend    <= '0;
      dwell   <= '0;
`ifdef LIFT_HOME_RETURN_EN
      home_cnt <= '0;
      homing   <= 1'b0;
`endif
    end else begin
      state   <= state_nxt;
      floor_q <= floor_nxt;
      dir     <= dir_nxt;
      pend    <= (pend | HallReq) & ~clr;
      dwell   <= dwell_nxt;
`ifdef LIFT_HOME_RETURN_EN
      home_cnt <= home_cnt_nxt;
      homing   <= homing_nxt;
`endif
    end
  end

  assign StepDir = dir;
  assign Floor   = floor_q;
  assign Pending = pend;

endmodule

// File: tb/tb_lift_request_scheduler.sv
// Directed bench for lift_request_scheduler: the bench plays the motion unit and
// compares outputs against hand-derived values; homing path under LIFT_HOME_RETURN_EN.
module tb_lift_request_scheduler;

  logic       Clock, Reset, StepReady, Arrive;
  logic [5:0] HallReq;
  logic       StepValid, StepDir, DoorOpen;
  logic [1:0] Action, Floor;
  logic [5:0] Pending;

  int n_chk  = 0;
  int n_fail = 0;

  lift_request_scheduler dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .HallReq  (HallReq),
    .StepReady(StepReady),
    .Arrive   (Arrive),
    .StepValid(StepValid),
    .StepDir  (StepDir),
    .Action   (Action),
    .Floor    (Floor),
    .DoorOpen (DoorOpen),
    .Pending  (Pending)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic wait_valid(input int max);
    int n = 0;
    while (!StepValid && n < max) begin
      tick();
      n++;
    end
    chk("step_valid_wait", 32'(StepValid), 1);
  endtask

  // Accept one step, optionally press buttons mid-move, then report arrival.
  task automatic do_step(input logic exp_dir, input logic [5:0] press);
    wait_valid(150);
    chk("step_dir", 32'(StepDir), 32'(exp_dir));
    chk("action_dir", 32'(Action), 32'(exp_dir));
    StepReady = 1'b1;
    tick();
    StepReady = 1'b0;
    chk("valid_drop", 32'(StepValid), 0);
    HallReq = press;
    tick();
    HallReq = '0;
    tick();
    Arrive = 1'b1;
    tick();
    Arrive = 1'b0;
  endtask

  task automatic count_door(output int n);
    n = 0;
    while (DoorOpen && n < 100) begin
      n++;
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int seen;
    Reset = 1'b1; HallReq = '0; StepReady = 1'b0; Arrive = 1'b0;
    tick(); tick();
    chk("rst_action", 32'(Action), 3);
    chk("rst_floor", 32'(Floor), 0);
    chk("rst_pending", 32'(Pending), 0);
    chk("rst_valid", 32'(StepValid), 0);
    chk("rst_door", 32'(DoorOpen), 0);
    Reset = 1'b0;
    tick();
    chk("init_to_idle", 32'(Action), 2);

    // 4D from floor 1: three up steps, reversal stop at the top.
    HallReq = 6'b100000;
    tick();
    HallReq = '0;
    chk("t1_latch", 32'(Pending), 32'h20);
    chk("t1_latency_c1", 32'(StepValid), 0);
    tick();
    chk("t1_latency_c2", 32'(StepValid), 1);
    chk("t1_dir", 32'(StepDir), 0);
    // Motion unit stalls: command must hold steady.
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t3_hold_valid", 32'(StepValid), 1);
      chk("t3_hold_dir", 32'(StepDir), 0);
      chk("t3_hold_floor", 32'(Floor), 0);
    end
    do_step(1'b0, 6'd0);
    chk("t1_floor1", 32'(Floor), 1);
    chk("t1_nodoor1", 32'(DoorOpen), 0);
    do_step(1'b0, 6'd0);
    chk("t1_floor2", 32'(Floor), 2);
    do_step(1'b0, 6'd0);
    chk("t1_floor3", 32'(Floor), 3);
    chk("t1_door", 32'(DoorOpen), 1);
    chk("t1_pending", 32'(Pending), 0);
    count_door(n);
    chk("t1_dwell", 32'(n), 8);
    chk("t1_idle", 32'(Action), 2);
    chk("t1_idle_valid", 32'(StepValid), 0);

    // Reset during a down move; the late Arrive must be ignored.
    HallReq = 6'b000001;
    tick();
    HallReq = '0;
    wait_valid(20);
    chk("t4_dir", 32'(StepDir), 1);
    StepReady = 1'b1;
    tick();
    StepReady = 1'b0;
    Reset = 1'b1;
    tick();
    chk("t4_floor", 32'(Floor), 0);
    chk("t4_pending", 32'(Pending), 0);
    chk("t4_action", 32'(Action), 3);
    chk("t4_valid", 32'(StepValid), 0);
    Reset = 1'b0;
    Arrive = 1'b1;
    tick();
    Arrive = 1'b0;
    chk("t4_after_action", 32'(Action), 2);
    chk("t4_after_floor", 32'(Floor), 0);
    seen = 0;
    repeat (5) begin
      tick();
      if (StepValid) seen++;
    end
    chk("t4_no_step", 32'(seen), 0);

    // 3D first, 2U pressed while moving: stop at 2 (2U), then 3 (3D, reversal).
    HallReq = 6'b010000;
    tick();
    HallReq = '0;
    do_step(1'b0, 6'b000010);
    chk("t2_floor1", 32'(Floor), 1);
    chk("t2_door1", 32'(DoorOpen), 1);
    chk("t2_pend1", 32'(Pending), 32'h10);
    count_door(n);
    chk("t2_dwell1", 32'(n), 8);
    do_step(1'b0, 6'd0);
    chk("t2_floor2", 32'(Floor), 2);
    chk("t2_door2", 32'(DoorOpen), 1);
    chk("t2_pend2", 32'(Pending), 0);
    count_door(n);
    chk("t2_dwell2", 32'(n), 8);
    chk("t2_idle", 32'(Action), 2);
    chk("t2_idle_valid", 32'(StepValid), 0);

    // Call at the current floor: door opens without a step; held press is cleared.
    HallReq = 6'b010000;
    tick();
    chk("t5_latch", 32'(Pending), 32'h10);
    chk("t5_nodoor", 32'(DoorOpen), 0);
    tick();
    chk("t5_door", 32'(DoorOpen), 1);
    chk("t5_clr_wins", 32'(Pending), 0);
    chk("t5_no_valid", 32'(StepValid), 0);
    HallReq = '0;
    // Re-press 3D during dwell: served again and dwell restarts.
    n = 0;
    while (DoorOpen && n < 100) begin
      n++;
      HallReq = (n == 3) ? 6'b010000 : 6'd0;
      tick();
    end
    HallReq = '0;
    chk("t5_restart_len", 32'(n), 12);
    chk("t5_pending", 32'(Pending), 0);
    chk("t5_idle", 32'(Action), 2);

`ifdef LIFT_HOME_RETURN_EN
    do_step(1'b1, 6'd0);
    chk("t6_floor1", 32'(Floor), 1);
    do_step(1'b1, 6'd0);
    chk("t6_floor0", 32'(Floor), 0);
    chk("t6_nodoor", 32'(DoorOpen), 0);
    tick();
    chk("t6_idle", 32'(Action), 2);
`else
    seen = 0;
    repeat (100) begin
      tick();
      if (StepValid) seen++;
    end
    chk("park_no_step", 32'(seen), 0);
    chk("park_floor", 32'(Floor), 2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
